// File: rtl/c0_5_pkg.sv
// Shared types for the mod-N counter sampling monitor: FSM states, step
// classes and the default modulus.
package c0_5_pkg;

  typedef enum logic [2:0] {
    ACQUIRE    = 3'd0,
    SYNC       = 3'd1,
    TRACK_UP   = 3'd2,
    TRACK_DOWN = 3'd3,
    FAULT      = 3'd4
  } mon_state_t;

  typedef enum logic [2:0] {
    S_HOLD    = 3'd0,
    S_UP      = 3'd1,
    S_DOWN    = 3'd2,
    S_JUMP    = 3'd3,
    S_ILLEGAL = 3'd4
  } step_t;

  localparam int C0_5_MOD = 6;

endpackage

// File: rtl/c0_5_step_classify.sv
// Combinational step classifier: compares a new count sample against the
// previous legal sample and reports the step class and whether it wraps.
module c0_5_step_classify
  import c0_5_pkg::*;
#(
  parameter int MOD = C0_5_MOD
) (
  input  logic [3:0] prev,
  input  logic [3:0] q,
  input  logic       reverse,
  output step_t      step,
  output logic       is_wrap
);

  localparam logic [3:0] LAST = 4'(MOD - 1);

  logic [3:0] up_nxt;
  logic [3:0] dn_nxt;
  logic       up_hit;
  logic       dn_hit;

  always_comb begin
    up_nxt = (prev == LAST) ? 4'd0 : prev + 4'd1;
    dn_nxt = (prev == 4'd0) ? LAST : prev - 4'd1;
    up_hit = (q == up_nxt);
    dn_hit = (q == dn_nxt);

    step = S_JUMP;
    if (q > LAST)
      step = S_ILLEGAL;
    else if (q == prev)
      step = S_HOLD;
    else if (up_hit && dn_hit)
      // Only reachable for MOD = 2: the commanded direction breaks the tie.
      step = reverse ? S_DOWN : S_UP;
    else if (up_hit)
      step = S_UP;
    else if (dn_hit)
      step = S_DOWN;

    is_wrap = ((step == S_UP) && (prev == LAST)) ||
              ((step == S_DOWN) && (prev == 4'd0));
  end

endmodule

// File: rtl/c0_5_monitor.sv
// Sampling monitor for the mod-N reversible counter: infers direction, flags
// wraps/faults/mismatches. Optional wrap counter: C0_5_MONITOR_WRAPCNT_EN.
module c0_5_monitor
  import c0_5_pkg::*;
#(
  parameter int MOD   = C0_5_MOD,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             reverse,
  input  logic [3:0]       q,
  output logic             dir_valid,
  output logic             dir_down,
  output logic             wrap,
  output logic             err,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       wrap_count
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  mon_state_t state, nstate;
  logic [3:0] prev, nprev;
  step_t      step;
  logic       is_wrap;
  logic       n_wrap, n_err, n_mis;

  c0_5_step_classify #(.MOD(MOD)) u_cls (
    .prev    (prev),
    .q       (q),
    .reverse (reverse),
    .step    (step),
    .is_wrap (is_wrap)
  );

  always_comb begin
    nstate = state;
    nprev  = prev;
    n_wrap = 1'b0;
    n_err  = 1'b0;
    n_mis  = 1'b0;
    if (step != S_ILLEGAL)
      nprev = q;
    case (state)
      ACQUIRE, FAULT: begin
        // No step is inferred here: a legal sample only re-seeds prev.
        if (step == S_ILLEGAL) begin
          n_err  = 1'b1;
          nstate = FAULT;
        end else begin
          nstate = SYNC;
        end
      end
      SYNC, TRACK_UP, TRACK_DOWN: begin
        case (step)
          S_HOLD: nstate = state;
          S_UP: begin
            nstate = TRACK_UP;
            n_wrap = is_wrap;
            n_mis  = reverse;
          end
          S_DOWN: begin
            nstate = TRACK_DOWN;
            n_wrap = is_wrap;
            n_mis  = ~reverse;
          end
          default: begin
            n_err  = 1'b1;
            nstate = FAULT;
          end
        endcase
      end
      default: nstate = ACQUIRE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ACQUIRE;
      prev      <= 4'd0;
      wrap      <= 1'b0;
      err       <= 1'b0;
      mismatch  <= 1'b0;
      err_count <= '0;
    end else begin
      wrap     <= enable & n_wrap;
      err      <= enable & n_err;
      mismatch <= enable & n_mis;
      if (enable) begin
        state <= nstate;
        prev  <= nprev;
        if (n_err && (err_count != ERR_MAX))
          err_count <= err_count + 1'b1;
      end
    end
  end

  assign dir_valid = (state == TRACK_UP) || (state == TRACK_DOWN);
  assign dir_down  = (state == TRACK_DOWN);

`ifdef C0_5_MONITOR_WRAPCNT_EN
  logic [7:0] wcnt;
  always_ff @(posedge clk) begin
    if (reset)
      wcnt <= 8'd0;
    else if (enable && n_wrap)
      wcnt <= wcnt + 8'd1;
  end
  assign wrap_count = wcnt;
`else
  assign wrap_count = 8'd0;
`endif

endmodule

// File: tb/tb_c0_5_monitor.sv
// Scoreboard bench for c0_5_monitor: directed samples push expectations,
// a monitor process pops and compares one entry per clock.
module tb_c0_5_monitor;
  import c0_5_pkg::*;

`ifdef C0_5_MONITOR_WRAPCNT_EN
  localparam bit WC_EN = 1'b1;
`else
  localparam bit WC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       reverse = 1'b0;
  logic [3:0] q = 4'd0;
  logic       dir_valid, dir_down, wrap, err, mismatch;
  logic [7:0] err_count, wrap_count;

  c0_5_monitor #(.MOD(6), .ERR_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .reverse    (reverse),
    .q          (q),
    .dir_valid  (dir_valid),
    .dir_down   (dir_down),
    .wrap       (wrap),
    .err        (err),
    .mismatch   (mismatch),
    .err_count  (err_count),
    .wrap_count (wrap_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] flags;  // dv, dd, wrap, err, mismatch
    logic [7:0] ec;
    logic [7:0] wc;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic apply(input logic r, input logic en, input logic rev,
                       input logic [3:0] qv, input logic dv, input logic dd,
                       input logic wr, input logic er, input logic mm,
                       input int ec, input int wc, input string tag);
    exp_t e;
    @(negedge clk);
    reset   = r;
    enable  = en;
    reverse = rev;
    q       = qv;
    e.flags = {dv, dd, wr, er, mm};
    e.ec    = 8'(ec);
    e.wc    = WC_EN ? 8'(wc % 256) : 8'd0;
    e.tag   = tag;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t       e;
    logic [4:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        got = {dir_valid, dir_down, wrap, err, mismatch};
        n_vec++;
        if (got !== e.flags || err_count !== e.ec || wrap_count !== e.wc) begin
          n_miss++;
          $display("FAIL %s: got dv/dd/wr/er/mm=%b ec=%0d wc=%0d, want %b ec=%0d wc=%0d",
                   e.tag, got, err_count, wrap_count, e.flags, e.ec, e.wc);
        end
      end
    end
  end

  initial begin : stim
    int nw;
    int guard;
    // Up count with a wrap on 5 -> 0
    apply(1, 0, 0, 0,  0,0,0,0,0, 0,0, "reset");
    apply(0, 1, 0, 0,  0,0,0,0,0, 0,0, "acq0");
    apply(0, 1, 0, 1,  1,0,0,0,0, 0,0, "up1");
    apply(0, 1, 0, 2,  1,0,0,0,0, 0,0, "up2");
    apply(0, 1, 0, 3,  1,0,0,0,0, 0,0, "up3");
    apply(0, 1, 0, 4,  1,0,0,0,0, 0,0, "up4");
    apply(0, 1, 0, 5,  1,0,0,0,0, 0,0, "up5");
    apply(0, 1, 0, 0,  1,0,1,0,0, 0,1, "wrap_up");
    // Down count with a wrap on 0 -> 5, then a hold
    apply(1, 1, 1, 0,  0,0,0,0,0, 0,0, "reset2");
    apply(0, 1, 1, 2,  0,0,0,0,0, 0,0, "acq2");
    apply(0, 1, 1, 1,  1,1,0,0,0, 0,0, "dn1");
    apply(0, 1, 1, 0,  1,1,0,0,0, 0,0, "dn0");
    apply(0, 1, 1, 5,  1,1,1,0,0, 0,1, "wrap_dn");
    apply(0, 1, 1, 5,  1,1,0,0,0, 0,1, "hold");
    // Direction reversal against reverse = 0
    apply(1, 0, 0, 0,  0,0,0,0,0, 0,0, "reset3");
    apply(0, 1, 0, 3,  0,0,0,0,0, 0,0, "acq3");
    apply(0, 1, 0, 4,  1,0,0,0,0, 0,0, "up4b");
    apply(0, 1, 0, 3,  1,1,0,0,1, 0,0, "rev_mm");
    apply(0, 1, 0, 2,  1,1,0,0,1, 0,0, "dn_mm");
    // Jump, illegal, recovery
    apply(1, 0, 0, 0,  0,0,0,0,0, 0,0, "reset4");
    apply(0, 1, 0, 1,  0,0,0,0,0, 0,0, "acq1");
    apply(0, 1, 0, 4,  0,0,0,1,0, 1,0, "jump");
    apply(0, 1, 0, 6,  0,0,0,1,0, 2,0, "illegal6");
    apply(0, 1, 0, 2,  0,0,0,0,0, 2,0, "fault_exit");
    apply(0, 1, 0, 3,  1,0,0,0,0, 2,0, "sync_up");
    // Enable low freezes state; reset beats enable
    apply(0, 0, 0, 5,  1,0,0,0,0, 2,0, "en_low");
    apply(0, 1, 0, 4,  1,0,0,0,0, 2,0, "en_high");
    apply(1, 1, 0, 5,  0,0,0,0,0, 0,0, "mid_reset");
    // 259 up-wraps: wrap_count rolls over modulo 256
    nw = 0;
    for (int k = 0; k <= 259 * 6; k++) begin
      if (k > 0 && (k % 6) == 0) nw++;
      apply(0, 1, 0, 4'(k % 6), (k > 0), 0, (k > 0 && (k % 6) == 0), 0, 0,
            0, nw, "wrap_loop");
    end
    // 300 illegal samples: err_count saturates
    apply(1, 0, 0, 0,  0,0,0,0,0, 0,0, "reset5");
    for (int i = 1; i <= 300; i++)
      apply(0, 1, 0, 4'd15, 0, 0, 0, 1, 0, (i > 255) ? 255 : i, 0, "err_sat");
    apply(0, 0, 0, 4'd15, 0,0,0,0,0, 255,0, "err_idle");

    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (sb.size() > 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
